// File: rtl/ula_executor.sv
// rtl/ula_executor.sv - multi-cycle ALU executor: single-cycle logic/arith, iterative shifts
module ula_executor #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       selection,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_zero,
    output logic             flag_neg,
    output logic             flag_carry,
    output logic             flag_overflow,
    output logic             illegal_op,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [SHW-1:0]   cnt;
    logic [4:0]       sel_q;
    logic             shift_carry;

    logic             accept;
    logic             is_shift;
    logic             is_arith;
    logic             is_illegal;
    logic [WIDTH-1:0] lres;
    logic [WIDTH-1:0] bx;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic             ovf;
    logic [WIDTH-1:0] res_now;
    logic [WIDTH-1:0] next_work;
    logic             out_bit;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state == SHIFT);

    // Single-cycle datapath; arithmetic always goes through one adder with a carry-in
    always_comb begin
        lres       = '0;
        bx         = '0;
        cin        = 1'b0;
        is_arith   = 1'b0;
        is_shift   = (selection >= 5'd17) && (selection <= 5'd19);
        is_illegal = (selection >= 5'd20);
        case (selection)
            5'd0:  lres = ~op_a;
            5'd1:  lres = op_a & op_b;
            5'd2:  lres = ~op_a & op_b;
            5'd3:  lres = op_a & ~op_b;
            5'd4:  lres = ~(op_a & op_b);
            5'd5:  lres = op_a | op_b;
            5'd6:  lres = ~op_a | op_b;
            5'd7:  lres = op_a | ~op_b;
            5'd8:  lres = ~(op_a | op_b);
            5'd9:  lres = op_a ^ op_b;
            5'd10: lres = ~(op_a ^ op_b);
            5'd11: begin is_arith = 1'b1; bx = op_b;  cin = 1'b0; end
            5'd12: begin is_arith = 1'b1; bx = op_b;  cin = 1'b1; end
            5'd13: begin is_arith = 1'b1; bx = '0;    cin = 1'b1; end
            5'd14: begin is_arith = 1'b1; bx = ~op_b; cin = 1'b1; end
            5'd15: begin is_arith = 1'b1; bx = ~op_b; cin = 1'b0; end
            5'd16: begin is_arith = 1'b1; bx = '1;    cin = 1'b0; end
            default: lres = '0;
        endcase
        sum = {1'b0, op_a} + {1'b0, bx} + {{WIDTH{1'b0}}, cin};
        ovf = (op_a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
        if (is_illegal)
            res_now = '0;
        else if (is_arith)
            res_now = sum[WIDTH-1:0];
        else
            res_now = lres;
    end

    always_comb begin
        next_work = {1'b0, work[WIDTH-1:1]};
        out_bit   = work[0];
        case (sel_q)
            5'd17: begin next_work = {work[WIDTH-2:0], 1'b0}; out_bit = work[WIDTH-1]; end
            5'd19: next_work = {work[WIDTH-1], work[WIDTH-1:1]};
            default: next_work = {1'b0, work[WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            work          <= '0;
            cnt           <= '0;
            sel_q         <= '0;
            shift_carry   <= 1'b0;
            result        <= '0;
            flag_zero     <= 1'b0;
            flag_neg      <= 1'b0;
            flag_carry    <= 1'b0;
            flag_overflow <= 1'b0;
            illegal_op    <= 1'b0;
        end else if (accept) begin
            if (is_shift) begin
                state       <= SHIFT;
                work        <= op_a;
                cnt         <= op_b[SHW-1:0];
                sel_q       <= selection;
                shift_carry <= 1'b0;
            end else begin
                state         <= DONE;
                result        <= res_now;
                flag_zero     <= !is_illegal && (res_now == '0);
                flag_neg      <= res_now[WIDTH-1];
                flag_carry    <= is_arith && sum[WIDTH];
                flag_overflow <= is_arith && ovf;
                illegal_op    <= is_illegal;
            end
        end else begin
            case (state)
                SHIFT: begin
                    // The zero-count cycle publishes the working register
                    if (cnt == '0) begin
                        state         <= DONE;
                        result        <= work;
                        flag_zero     <= (work == '0);
                        flag_neg      <= work[WIDTH-1];
                        flag_carry    <= shift_carry;
                        flag_overflow <= 1'b0;
                        illegal_op    <= 1'b0;
                    end else begin
                        work        <= next_work;
                        shift_carry <= out_bit;
                        cnt         <= cnt - 1'b1;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ula_executor.sv
// tb/tb_ula_executor.sv - directed self-checking bench for ula_executor at WIDTH=8
module tb_ula_executor;
    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] selection;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       flag_zero, flag_neg, flag_carry, flag_overflow;
    logic       illegal_op;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    ula_executor #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .selection(selection), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result),
        .flag_zero(flag_zero), .flag_neg(flag_neg),
        .flag_carry(flag_carry), .flag_overflow(flag_overflow),
        .illegal_op(illegal_op), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request and advances through its acceptance edge
    task automatic issue(input logic [4:0] s, input logic [7:0] a, input logic [7:0] b);
        in_valid  = 1'b1;
        selection = s;
        op_a      = a;
        op_b      = b;
        step();
        in_valid  = 1'b0;
        selection = 5'd31;
        op_a      = 8'h55;
        op_b      = 8'h55;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        n_cmp++;
        if ({in_ready, out_valid, busy, illegal_op} !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_ctrl: got rdy/vld/busy/ill=%b want 1000", {in_ready, out_valid, busy, illegal_op});
        end
        n_cmp++;
        if ({result, flag_zero, flag_neg, flag_carry, flag_overflow} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_data: got result=%h flags=%b want 00 0000", result,
                     {flag_zero, flag_neg, flag_carry, flag_overflow});
        end
    endtask

    task automatic test_add();
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL add_in_ready: got %b want 1", in_ready);
        end
        issue(5'd11, 8'h7F, 8'h01);
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL add_latency: out_valid=%b one cycle after accept, want 1", out_valid);
        end
        n_cmp++;
        if ({result, flag_zero, flag_neg, flag_carry, flag_overflow} !== {8'h80, 4'b0101}) begin
            n_err++;
            $display("FAIL add_value: got %h zncv=%b want 80 0101", result,
                     {flag_zero, flag_neg, flag_carry, flag_overflow});
        end
        pop();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL add_pop: out_valid=%b after pop, want 0", out_valid);
        end
    endtask

    task automatic test_sub();
        issue(5'd14, 8'h05, 8'h05);
        n_cmp++;
        if ({out_valid, result, flag_zero, flag_neg, flag_carry, flag_overflow} !== {1'b1, 8'h00, 4'b1010}) begin
            n_err++;
            $display("FAIL sub_value: got vld=%b %h zncv=%b want 1 00 1010", out_valid, result,
                     {flag_zero, flag_neg, flag_carry, flag_overflow});
        end
        pop();
        issue(5'd16, 8'h00, 8'h00);
        n_cmp++;
        if ({out_valid, result, flag_zero, flag_neg, flag_carry, flag_overflow} !== {1'b1, 8'hFF, 4'b0100}) begin
            n_err++;
            $display("FAIL dec_value: got vld=%b %h zncv=%b want 1 ff 0100", out_valid, result,
                     {flag_zero, flag_neg, flag_carry, flag_overflow});
        end
        pop();
    endtask

    task automatic run_shift(input string name, input logic [4:0] s, input logic [7:0] a,
                             input logic [7:0] b, input int exp_edges, input int exp_busy,
                             input logic [7:0] exp_res, input logic [3:0] exp_flags);
        int edges;
        int busy_cnt;
        issue(s, a, b);
        edges    = 1;
        busy_cnt = busy ? 1 : 0;
        while (!out_valid && edges < 30) begin
            step();
            edges++;
            if (busy) busy_cnt++;
        end
        n_cmp++;
        if (edges !== exp_edges || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL %s_latency: got %0d edges vld=%b want %0d", name, edges, out_valid, exp_edges);
        end
        n_cmp++;
        if (busy_cnt !== exp_busy) begin
            n_err++;
            $display("FAIL %s_busy: got %0d busy cycles want %0d", name, busy_cnt, exp_busy);
        end
        n_cmp++;
        if ({result, flag_zero, flag_neg, flag_carry, flag_overflow} !== {exp_res, exp_flags}) begin
            n_err++;
            $display("FAIL %s_value: got %h zncv=%b want %h %b", name, result,
                     {flag_zero, flag_neg, flag_carry, flag_overflow}, exp_res, exp_flags);
        end
        pop();
    endtask

    task automatic test_shift();
        run_shift("asr3", 5'd19, 8'h90, 8'd3, 5, 4, 8'hF2, 4'b0100);
        run_shift("asr0", 5'd19, 8'h90, 8'd0, 2, 1, 8'h90, 4'b0100);
        run_shift("lsl1", 5'd17, 8'h81, 8'd1, 3, 2, 8'h02, 4'b0010);
        run_shift("lsr2", 5'd18, 8'h03, 8'd2, 4, 3, 8'h00, 4'b1010);
    endtask

    task automatic test_back_to_back();
        issue(5'd1, 8'hF0, 8'h3C);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({out_valid, in_ready, result} !== {2'b10, 8'h30}) begin
                n_err++;
                $display("FAIL hold_%0d: got vld=%b rdy=%b %h want 1 0 30", i, out_valid, in_ready, result);
            end
            step();
        end
        in_valid  = 1'b1;
        selection = 5'd9;
        op_a      = 8'hF0;
        op_b      = 8'h3C;
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_ready: got %b want 1", in_ready);
        end
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_cmp++;
        if ({out_valid, result} !== {1'b1, 8'hCC}) begin
            n_err++;
            $display("FAIL b2b_value: got vld=%b %h want 1 cc", out_valid, result);
        end
        pop();
    endtask

    task automatic test_illegal_reset();
        int seen;
        issue(5'd25, 8'hAB, 8'hCD);
        n_cmp++;
        if ({out_valid, illegal_op, result, flag_zero, flag_neg, flag_carry, flag_overflow} !==
            {2'b11, 8'h00, 4'b0000}) begin
            n_err++;
            $display("FAIL illegal: got vld=%b ill=%b %h zncv=%b want 1 1 00 0000", out_valid, illegal_op,
                     result, {flag_zero, flag_neg, flag_carry, flag_overflow});
        end
        pop();
        issue(5'd17, 8'h01, 8'd7);
        step();
        step();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL midshift_busy: got %b want 1", busy);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            n_err++;
            $display("FAIL abort_state: got rdy/vld/busy=%b want 100", {in_ready, out_valid, busy});
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL abort_no_output: out_valid seen %0d cycles want 0", seen);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        selection = 5'd0;
        op_a      = 8'h00;
        op_b      = 8'h00;
        test_reset();
        test_add();
        test_sub();
        test_shift();
        test_back_to_back();
        test_illegal_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
